// File: rtl/riscv_execute_stage.sv
// RV32I execute stage: ALU, branch/jump resolution and the EX/MEM register.
// Shifts run through an iterative shifter and hold the ID/EX register via o_stall.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_execute_stage #(
  parameter logic [`XLEN-1:0] REGISTER_INIT = '0,
  parameter int unsigned      SHIFT_STEP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  input  logic [`XLEN-1:0]   i_pc,
  input  logic [`XLEN-1:0]   i_rs1_data,
  input  logic [`XLEN-1:0]   i_rs2_data,
  input  logic [`XLEN-1:0]   i_imm,
  input  logic               i_src_b_sel,
  input  logic [3:0]         i_alu_op,
  input  logic [2:0]         i_br_type,
  input  logic [1:0]         i_jump,
  input  logic [4:0]         i_rd_addr,
  input  logic               i_reg_wen,
  input  logic               i_mem_stall,
  output logic               o_stall,
  output logic               o_redirect,
  output logic [`XLEN-1:0]   o_redirect_pc,
  output logic               o_valid,
  output logic [`XLEN-1:0]   o_alu_result,
  output logic [`XLEN-1:0]   o_rs2_data,
  output logic [4:0]         o_rd_addr,
  output logic               o_reg_wen
);

  localparam int         W    = `XLEN;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [4:0]   count, count_next;
  logic [W-1:0] sh_reg, sh_reg_next;
  logic [3:0]   sh_op, sh_op_next;

  logic [W-1:0] op_b;
  logic [W-1:0] pc_imm;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] jalr_target;
  logic [W-1:0] alu_result;
  logic [W-1:0] ex_result;
  logic [W-1:0] cap_result;
  logic [W-1:0] step_val;
  logic [W-1:0] redirect_target;
  logic [4:0]   shamt;
  logic [4:0]   step_amt;
  logic         is_jump;
  logic         is_shift_op;
  logic         shift_start;
  logic         br_taken;
  logic         redirect_en;
  logic         cap;
  logic         bubble;

  function automatic logic [W-1:0] shift_by(input logic [3:0] op,
                                            input logic [W-1:0] v,
                                            input logic [4:0] amt);
    logic [W-1:0] r;
    case (op)
      OP_SLL:  r = v << amt;
      OP_SRL:  r = v >> amt;
      default: r = $unsigned($signed(v) >>> amt);
    endcase
    return r;
  endfunction

  assign op_b        = i_src_b_sel ? i_imm : i_rs2_data;
  assign shamt       = op_b[4:0];
  assign pc_imm      = i_pc + i_imm;
  assign pc_plus4    = i_pc + W'(4);
  assign jalr_target = (i_rs1_data + i_imm) & ~W'(1);
  assign is_jump     = (i_jump == 2'd1) || (i_jump == 2'd2);
  assign is_shift_op = !is_jump &&
                       ((i_alu_op == OP_SLL) || (i_alu_op == OP_SRL) || (i_alu_op == OP_SRA));
  assign shift_start = (state == IDLE) && i_valid && !i_mem_stall && is_shift_op && (shamt != 5'd0);

  // Single-cycle ALU; shift ops here only serve the shamt==0 case (result = A).
  always_comb begin
    alu_result = '0;
    case (i_alu_op)
      OP_ADD:   alu_result = i_rs1_data + op_b;
      OP_SUB:   alu_result = i_rs1_data - op_b;
      OP_SLL:   alu_result = i_rs1_data;
      OP_SLT:   alu_result = {{(W-1){1'b0}}, ($signed(i_rs1_data) < $signed(op_b))};
      OP_SLTU:  alu_result = {{(W-1){1'b0}}, (i_rs1_data < op_b)};
      OP_XOR:   alu_result = i_rs1_data ^ op_b;
      OP_SRL:   alu_result = i_rs1_data;
      OP_SRA:   alu_result = i_rs1_data;
      OP_OR:    alu_result = i_rs1_data | op_b;
      OP_AND:   alu_result = i_rs1_data & op_b;
      OP_LUI:   alu_result = op_b;
      OP_AUIPC: alu_result = pc_imm;
      default:  alu_result = '0;
    endcase
  end

  assign ex_result = is_jump ? pc_plus4 : alu_result;

  // Branches always compare rs1 against rs2, never against the immediate.
  always_comb begin
    br_taken = 1'b0;
    case (i_br_type)
      3'd1:    br_taken = (i_rs1_data == i_rs2_data);
      3'd2:    br_taken = (i_rs1_data != i_rs2_data);
      3'd3:    br_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      3'd4:    br_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      3'd5:    br_taken = (i_rs1_data <  i_rs2_data);
      3'd6:    br_taken = (i_rs1_data >= i_rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect_target = (i_jump == 2'd2) ? jalr_target : pc_imm;
  assign redirect_en     = i_rstn && i_valid && (state == IDLE) && !i_mem_stall &&
                           (is_jump || br_taken);

  assign o_redirect    = redirect_en;
  assign o_redirect_pc = redirect_en ? redirect_target : '0;
  assign o_stall       = i_rstn &&
                         (i_mem_stall || shift_start || ((state == SHIFT) && (count > STEP)));

  assign step_amt = (count > STEP) ? STEP : count;
  assign step_val = shift_by(sh_op, sh_reg, step_amt);

  // Next-state logic; a downstream stall freezes everything by leaving the defaults.
  always_comb begin
    state_next  = state;
    count_next  = count;
    sh_reg_next = sh_reg;
    sh_op_next  = sh_op;
    cap         = 1'b0;
    bubble      = 1'b0;
    cap_result  = ex_result;
    if (!i_mem_stall) begin
      case (state)
        IDLE: begin
          if (shift_start) begin
            state_next  = SHIFT;
            count_next  = shamt;
            sh_reg_next = i_rs1_data;
            sh_op_next  = i_alu_op;
            bubble      = 1'b1;
          end else if (i_valid) begin
            cap = 1'b1;
          end else begin
            bubble = 1'b1;
          end
        end
        SHIFT: begin
          sh_reg_next = step_val;
          count_next  = count - step_amt;
          if (count > STEP) begin
            bubble = 1'b1;
          end else begin
            cap        = 1'b1;
            cap_result = step_val;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      count  <= '0;
      sh_reg <= '0;
      sh_op  <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      sh_reg <= sh_reg_next;
      sh_op  <= sh_op_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid      <= 1'b0;
      o_alu_result <= REGISTER_INIT;
      o_rs2_data   <= REGISTER_INIT;
      o_rd_addr    <= '0;
      o_reg_wen    <= 1'b0;
    end else if (cap) begin
      o_valid      <= 1'b1;
      o_alu_result <= cap_result;
      o_rs2_data   <= i_rs2_data;
      o_rd_addr    <= i_rd_addr;
      o_reg_wen    <= i_reg_wen && (i_rd_addr != 5'd0);
    end else if (bubble) begin
      o_valid   <= 1'b0;
      o_reg_wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_execute_stage.sv
// Bench for riscv_execute_stage: two instances (SHIFT_STEP 1 and 4), directed
// scenarios plus randomized instructions checked against an arithmetic model.

module tb_riscv_execute_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        src_b_sel;
    logic [3:0]  alu_op;
    logic [2:0]  br_type;
    logic [1:0]  jump;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_stall;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_wen;
  } out_t;

  localparam logic [31:0] INIT1 = 32'hDEAD_BEEF;
  localparam logic [31:0] INIT4 = 32'h1234_5678;

  logic   clk;
  logic   rstn;
  instr_t in1, in4;
  out_t   o1, o4;
  int     n_checks;
  int     n_fail;

  logic        st1, rdr1, v1, wen1, st4, rdr4, v4, wen4;
  logic [31:0] rpc1, res1, rs2o1, rpc4, res4, rs2o4;
  logic [4:0]  rdo1, rdo4;

  assign o1 = {st1, rdr1, rpc1, v1, res1, rs2o1, rdo1, wen1};
  assign o4 = {st4, rdr4, rpc4, v4, res4, rs2o4, rdo4, wen4};

  riscv_execute_stage #(.REGISTER_INIT(INIT1), .SHIFT_STEP(1)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(in1.valid), .i_pc(in1.pc),
    .i_rs1_data(in1.rs1), .i_rs2_data(in1.rs2), .i_imm(in1.imm),
    .i_src_b_sel(in1.src_b_sel), .i_alu_op(in1.alu_op), .i_br_type(in1.br_type),
    .i_jump(in1.jump), .i_rd_addr(in1.rd), .i_reg_wen(in1.reg_wen),
    .i_mem_stall(in1.mem_stall), .o_stall(st1), .o_redirect(rdr1),
    .o_redirect_pc(rpc1), .o_valid(v1), .o_alu_result(res1), .o_rs2_data(rs2o1),
    .o_rd_addr(rdo1), .o_reg_wen(wen1)
  );

  riscv_execute_stage #(.REGISTER_INIT(INIT4), .SHIFT_STEP(4)) dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(in4.valid), .i_pc(in4.pc),
    .i_rs1_data(in4.rs1), .i_rs2_data(in4.rs2), .i_imm(in4.imm),
    .i_src_b_sel(in4.src_b_sel), .i_alu_op(in4.alu_op), .i_br_type(in4.br_type),
    .i_jump(in4.jump), .i_rd_addr(in4.rd), .i_reg_wen(in4.reg_wen),
    .i_mem_stall(in4.mem_stall), .o_stall(st4), .o_redirect(rdr4),
    .o_redirect_pc(rpc4), .o_valid(v4), .o_alu_result(res4), .o_rs2_data(rs2o4),
    .o_rd_addr(rdo4), .o_reg_wen(wen4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_result(input instr_t t);
    logic [31:0] b;
    logic [4:0]  sh;
    b  = t.src_b_sel ? t.imm : t.rs2;
    sh = b[4:0];
    if (t.jump == 2'd1 || t.jump == 2'd2) return t.pc + 32'd4;
    case (t.alu_op)
      4'd0:    return t.rs1 + b;
      4'd1:    return t.rs1 - b;
      4'd2:    return t.rs1 << sh;
      4'd3:    return ($signed(t.rs1) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (t.rs1 < b) ? 32'd1 : 32'd0;
      4'd5:    return t.rs1 ^ b;
      4'd6:    return t.rs1 >> sh;
      4'd7:    return $unsigned($signed(t.rs1) >>> sh);
      4'd8:    return t.rs1 | b;
      4'd9:    return t.rs1 & b;
      4'd10:   return b;
      4'd11:   return t.pc + t.imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_redirect(input instr_t t);
    logic signed [31:0] a, b;
    a = t.rs1;
    b = t.rs2;
    if (t.jump == 2'd1 || t.jump == 2'd2) return 1'b1;
    case (t.br_type)
      3'd1:    return t.rs1 == t.rs2;
      3'd2:    return t.rs1 != t.rs2;
      3'd3:    return a < b;
      3'd4:    return a >= b;
      3'd5:    return t.rs1 < t.rs2;
      3'd6:    return t.rs1 >= t.rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_target(input instr_t t);
    if (!exp_redirect(t)) return 32'd0;
    if (t.jump == 2'd2) return (t.rs1 + t.imm) & 32'hFFFF_FFFE;
    return t.pc + t.imm;
  endfunction

  // Cycles the instruction occupies the stage, ignoring downstream stalls.
  function automatic int exp_occupancy(input instr_t t, input int step);
    logic [31:0] b;
    int sh;
    b  = t.src_b_sel ? t.imm : t.rs2;
    sh = int'(b[4:0]);
    if (t.jump == 2'd1 || t.jump == 2'd2) return 1;
    if (!(t.alu_op == 4'd2 || t.alu_op == 4'd6 || t.alu_op == 4'd7)) return 1;
    if (sh == 0) return 1;
    return 1 + (sh + step - 1) / step;
  endfunction

  // ---------------- driver ----------------
  // Holds the instruction while o_stall is high; downstream stall is raised
  // for ms_len cycles starting at cycle ms_at. Returns with time at posedge+1.
  task automatic run_op(input int which, input instr_t ins, input int ms_at, input int ms_len,
                        output int cycles, output int stalls, output logic redir,
                        output logic [31:0] redir_pc, output out_t fin,
                        output logic held_bad, output logic timed_out);
    out_t cur, snap;
    bit   got_redir;
    cycles = 0; stalls = 0; redir = 1'b0; redir_pc = '0; held_bad = 1'b0;
    timed_out = 1'b1; got_redir = 1'b0; snap = '0;
    for (int c = 0; c < 200; c++) begin
      ins.mem_stall = (c >= ms_at) && (c < ms_at + ms_len);
      if (which == 4) in4 = ins; else in1 = ins;
      @(negedge clk);
      cur = (which == 4) ? o4 : o1;
      if (ms_len > 0 && c == ms_at) snap = cur;
      else if (ms_len > 0 && c > ms_at && c <= ms_at + ms_len &&
               {cur.valid, cur.result, cur.rs2, cur.rd, cur.reg_wen} !==
               {snap.valid, snap.result, snap.rs2, snap.rd, snap.reg_wen}) held_bad = 1'b1;
      if (!ins.mem_stall && !got_redir) begin
        got_redir = 1'b1;
        redir     = cur.redirect;
        redir_pc  = cur.redirect_pc;
      end
      if (cur.stall) stalls++;
      @(posedge clk);
      #1;
      cycles++;
      if (!cur.stall) begin
        timed_out = 1'b0;
        break;
      end
    end
    fin = (which == 4) ? o4 : o1;
    ins.valid = 1'b0;
    ins.mem_stall = 1'b0;
    if (which == 4) in4 = ins; else in1 = ins;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    instr_t t;
    t = '0; t.valid = 1'b1; t.jump = 2'd1; t.pc = 32'h40; t.imm = 32'h10;
    t.alu_op = 4'd7; t.rs2 = 32'd9; t.mem_stall = 1'b1;
    in1 = t; in4 = t;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (o1.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o1.valid); end
    n_checks++; if (o1.result !== INIT1) begin n_fail++; $display("FAIL reset_result1: got %h want %h", o1.result, INIT1); end
    n_checks++; if (o1.rs2 !== INIT1) begin n_fail++; $display("FAIL reset_rs2: got %h want %h", o1.rs2, INIT1); end
    n_checks++; if (o4.result !== INIT4) begin n_fail++; $display("FAIL reset_result4: got %h want %h", o4.result, INIT4); end
    n_checks++; if ({o1.rd, o1.reg_wen} !== 6'd0) begin n_fail++; $display("FAIL reset_rd_wen: got %h want 0", {o1.rd, o1.reg_wen}); end
    n_checks++; if ({o1.stall, o1.redirect, o1.redirect_pc} !== 34'd0) begin n_fail++; $display("FAIL reset_comb: got %h want 0", {o1.stall, o1.redirect, o1.redirect_pc}); end
    in1 = '0; in4 = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd0; t.rs1 = 32'h5; t.imm = 32'hFFFF_FFFD;
    t.src_b_sel = 1'b1; t.rd = 5'd3; t.reg_wen = 1'b1; t.rs2 = 32'hA5A5_0001;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if (to !== 1'b0 || cyc != 1) begin n_fail++; $display("FAIL add_latency: got %0d cycles want 1", cyc); end
    n_checks++; if ({f.valid, f.result} !== {1'b1, 32'h2}) begin n_fail++; $display("FAIL add_result: got %b/%h want 1/00000002", f.valid, f.result); end
    n_checks++; if ({f.reg_wen, f.rd} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL add_rd: got %b/%0d want 1/3", f.reg_wen, f.rd); end
    n_checks++; if (f.rs2 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL add_store_data: got %h want a5a50001", f.rs2); end
  endtask

  task automatic test_sra();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd7; t.rs1 = 32'h8000_0000; t.rs2 = 32'd5;
    t.rd = 5'd9; t.reg_wen = 1'b1;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if (to !== 1'b0 || stl != 5) begin n_fail++; $display("FAIL sra_step1_stall: got %0d want 5", stl); end
    n_checks++; if ({f.valid, f.result} !== {1'b1, 32'hFC00_0000}) begin n_fail++; $display("FAIL sra_step1_result: got %b/%h want 1/fc000000", f.valid, f.result); end
    run_op(4, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if (to !== 1'b0 || stl != 2) begin n_fail++; $display("FAIL sra_step4_stall: got %0d want 2", stl); end
    n_checks++; if (f.result !== 32'hFC00_0000) begin n_fail++; $display("FAIL sra_step4_result: got %h want fc000000", f.result); end
    t.rs2 = 32'h20;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if (to !== 1'b0 || stl != 0) begin n_fail++; $display("FAIL sra_shamt0_stall: got %0d want 0", stl); end
    n_checks++; if (f.result !== 32'h8000_0000) begin n_fail++; $display("FAIL sra_shamt0_result: got %h want 80000000", f.result); end
  endtask

  task automatic test_branch();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd1; t.br_type = 3'd3; t.rs1 = 32'hFFFF_FFFF;
    t.rs2 = 32'd1; t.pc = 32'h100; t.imm = 32'h20; t.src_b_sel = 1'b1;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({rd_, rpc} !== {1'b1, 32'h120}) begin n_fail++; $display("FAIL blt_redirect: got %b/%h want 1/00000120", rd_, rpc); end
    t.br_type = 3'd5;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({rd_, rpc} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL bltu_redirect: got %b/%h want 0/00000000", rd_, rpc); end
  endtask

  task automatic test_jalr();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.jump = 2'd2; t.alu_op = 4'd5; t.pc = 32'h200;
    t.rs1 = 32'h1003; t.imm = 32'h4; t.src_b_sel = 1'b1; t.rd = 5'd1; t.reg_wen = 1'b1;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({rd_, rpc} !== {1'b1, 32'h1006}) begin n_fail++; $display("FAIL jalr_target: got %b/%h want 1/00001006", rd_, rpc); end
    n_checks++; if ({f.result, f.reg_wen} !== {32'h204, 1'b1}) begin n_fail++; $display("FAIL jalr_link: got %h/%b want 00000204/1", f.result, f.reg_wen); end
    t.rd = 5'd0;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({f.valid, f.reg_wen} !== 2'b10) begin n_fail++; $display("FAIL jalr_rd0_wen: got %b/%b want 1/0", f.valid, f.reg_wen); end
  endtask

  task automatic test_mem_stall();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd2; t.rs1 = 32'h0000_0F0F; t.imm = 32'd6;
    t.src_b_sel = 1'b1; t.rd = 5'd12; t.reg_wen = 1'b1;
    run_op(1, t, 2, 3, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if (to !== 1'b0 || cyc != 10) begin n_fail++; $display("FAIL sll_memstall_occupancy: got %0d want 10", cyc); end
    n_checks++; if (f.result !== 32'h0003_C3C0) begin n_fail++; $display("FAIL sll_memstall_result: got %h want 0003c3c0", f.result); end
    n_checks++; if (hb !== 1'b0) begin n_fail++; $display("FAIL sll_memstall_hold: got %b want 0", hb); end
    // Jump issued under a downstream stall: redirect appears once the stall drops.
    t = '0; t.valid = 1'b1; t.jump = 2'd1; t.pc = 32'h300; t.imm = 32'h40; t.rd = 5'd2; t.reg_wen = 1'b1;
    run_op(1, t, 0, 2, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({rd_, rpc, cyc} !== {1'b1, 32'h340, 32'd3}) begin n_fail++; $display("FAIL jal_pending_redirect: got %b/%h/%0d want 1/00000340/3", rd_, rpc, cyc); end
    n_checks++; if ({hb, f.result} !== {1'b0, 32'h304}) begin n_fail++; $display("FAIL jal_pending_hold: got %b/%h want 0/00000304", hb, f.result); end
  endtask

  task automatic test_reset_mid_shift();
    instr_t t; out_t f; int cyc, stl; logic rd_, hb, to; logic [31:0] rpc;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd7; t.rs1 = 32'h8000_0000; t.rs2 = 32'd20;
    t.rd = 5'd7; t.reg_wen = 1'b1;
    in1 = t;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o1.stall !== 1'b1) begin n_fail++; $display("FAIL midshift_stalling: got %b want 1", o1.stall); end
    rstn = 1'b0;
    #1;
    n_checks++; if ({o1.valid, o1.stall, o1.result} !== {2'b00, INIT1}) begin n_fail++; $display("FAIL midshift_reset: got %b/%b/%h want 0/0/%h", o1.valid, o1.stall, o1.result, INIT1); end
    in1 = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    t = '0; t.valid = 1'b1; t.alu_op = 4'd0; t.rs1 = 32'd1; t.rs2 = 32'd1; t.rd = 5'd4; t.reg_wen = 1'b1;
    run_op(1, t, 0, 0, cyc, stl, rd_, rpc, f, hb, to);
    n_checks++; if ({f.valid, f.result, cyc} !== {1'b1, 32'd2, 32'd1}) begin n_fail++; $display("FAIL after_reset_add: got %b/%h/%0d want 1/00000002/1", f.valid, f.result, cyc); end
  endtask

  task automatic test_back_to_back();
    instr_t t; logic [31:0] exp_q[$]; logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      t = '0; t.valid = 1'b1;
      t.alu_op = (i % 3 == 0) ? 4'd0 : ((i % 3 == 1) ? 4'd1 : 4'd5);
      t.rs1 = $urandom; t.rs2 = $urandom; t.rd = 5'(i + 1); t.reg_wen = 1'b1;
      exp_q.push_back(exp_result(t));
      in1 = t;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++; if ({o1.valid, o1.stall, o1.result, o1.rd} !== {2'b10, e, 5'(i + 1)}) begin
        n_fail++; $display("FAIL b2b_%0d: got %b/%b/%h/%0d want 1/0/%h/%0d", i, o1.valid, o1.stall, o1.result, o1.rd, e, i + 1);
      end
    end
    in1 = '0;
    @(posedge clk);
    #1;
    n_checks++; if ({o1.valid, o1.reg_wen} !== 2'b00) begin n_fail++; $display("FAIL b2b_bubble: got %b/%b want 0/0", o1.valid, o1.reg_wen); end
  endtask

  task automatic test_random();
    instr_t t; out_t f; int cyc, stl, ms, which, step, eocc; logic rd_, hb, to; logic [31:0] rpc;
    for (int i = 0; i < 80; i++) begin
      which = (i % 2 == 0) ? 1 : 4;
      step  = (which == 4) ? 4 : 1;
      t = '0; t.valid = 1'b1;
      t.pc  = $urandom & 32'hFFFF_FFFC;
      t.rs1 = $urandom;
      t.rs2 = $urandom;
      if ($urandom_range(0, 3) == 0) t.rs2 = t.rs1;
      if ($urandom_range(0, 3) == 0) t.rs2 = 32'($urandom_range(0, 40));
      t.imm = $urandom;
      if ($urandom_range(0, 1) == 0) t.imm = 32'($urandom_range(0, 63)) - 32'd32;
      t.src_b_sel = 1'($urandom_range(0, 1));
      t.alu_op    = 4'($urandom_range(0, 15));
      t.br_type   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      t.jump      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      if ((t.br_type != 3'd0 || t.jump != 2'd0) &&
          (t.alu_op == 4'd2 || t.alu_op == 4'd6 || t.alu_op == 4'd7)) t.alu_op = 4'd0;
      t.rd      = 5'($urandom_range(0, 31));
      t.reg_wen = 1'($urandom_range(0, 1));
      ms = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      eocc = exp_occupancy(t, step) + ms;
      run_op(which, t, 0, ms, cyc, stl, rd_, rpc, f, hb, to);
      n_checks++; if (to !== 1'b0 || cyc != eocc || stl != eocc - 1) begin
        n_fail++; $display("FAIL rand_%0d_timing: got %0d cycles/%0d stalls want %0d/%0d", i, cyc, stl, eocc, eocc - 1);
      end
      n_checks++; if ({f.valid, f.result, f.rs2} !== {1'b1, exp_result(t), t.rs2}) begin
        n_fail++; $display("FAIL rand_%0d_result: op %0d got %b/%h/%h want 1/%h/%h", i, t.alu_op, f.valid, f.result, f.rs2, exp_result(t), t.rs2);
      end
      n_checks++; if ({f.rd, f.reg_wen} !== {t.rd, t.reg_wen && (t.rd != 5'd0)}) begin
        n_fail++; $display("FAIL rand_%0d_rd: got %0d/%b want %0d/%b", i, f.rd, f.reg_wen, t.rd, t.reg_wen && (t.rd != 5'd0));
      end
      n_checks++; if ({rd_, rpc} !== {exp_redirect(t), exp_target(t)}) begin
        n_fail++; $display("FAIL rand_%0d_redirect: br %0d jump %0d got %b/%h want %b/%h", i, t.br_type, t.jump, rd_, rpc, exp_redirect(t), exp_target(t));
      end
      n_checks++; if (hb !== 1'b0) begin n_fail++; $display("FAIL rand_%0d_hold: got %b want 0", i, hb); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    in1      = '0;
    in4      = '0;
    test_reset();
    test_add();
    test_sra();
    test_branch();
    test_jalr();
    test_mem_stall();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
